// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage -- rv32i writeback stage.
//
// Takes retiring instructions from the memory stage. For a load it waits for
// data memory, then extracts the byte or halfword and sign/zero extends it.
// It drives the registered register-file write port. It stalls the memory
// stage while a load is outstanding. It pulses o_load_err when a load is
// misaligned, has an illegal funct3, or times out.
//
// Parameters:
//   ACK_TIMEOUT  max cycles spent in WAIT before a load is abandoned (1..255)
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   i_valid/i_rd/i_rd_en          retiring instruction and its destination
//   i_alu_result                  result of a non-load instruction
//   i_is_load/i_funct3/i_addr_lsb load type and load address bits [1:0]
//   o_stall                       upstream must hold (a load is outstanding)
//   i_dmem_ack/i_dmem_rdata       load data handshake (word aligned, LE)
//   o_w_en/o_rd/o_rd_wdata        registered register-file write port
//   o_load_err                    one-cycle error pulse
//   o_fwd_valid/o_fwd_rd/o_fwd_data  forwarding port
//
// Optional feature macro: WB_FORWARD_EN
//   When defined, the forwarding port presents the current write. When there
//   is no current write, it presents the previous cycle's write.
//   When undefined, the forwarding outputs are tied to zero.
// ---------------------------------------------------------------------------
module wb_stage #(
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    input  logic [4:0]  i_rd,
    input  logic        i_rd_en,
    input  logic [31:0] i_alu_result,
    input  logic        i_is_load,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lsb,
    output logic        o_stall,
    input  logic        i_dmem_ack,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_w_en,
    output logic [4:0]  o_rd,
    output logic [31:0] o_rd_wdata,
    output logic        o_load_err,
    output logic        o_fwd_valid,
    output logic [4:0]  o_fwd_rd,
    output logic [31:0] o_fwd_data
);

    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [4:0]  ld_rd_q, ld_rd_d;
    logic        ld_rd_en_q, ld_rd_en_d;
    logic [2:0]  ld_funct3_q, ld_funct3_d;
    logic [1:0]  ld_lsb_q, ld_lsb_d;
    logic        w_en_q, w_en_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;

    logic        load_bad;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_fmt;

    // Reject a load at accept time: illegal funct3, or an address that is
    // not naturally aligned for its access size.
    always_comb begin
        load_bad = 1'b0;
        case (i_funct3)
            3'b011, 3'b110, 3'b111: load_bad = 1'b1;
            3'b001, 3'b101:         load_bad = i_addr_lsb[0];
            3'b010:                 load_bad = (i_addr_lsb != 2'b00);
            default:                load_bad = 1'b0;
        endcase
    end

    // Lane extraction from the little-endian data word, then extension.
    // funct3[2] selects zero extension (LBU/LHU).
    always_comb begin
        case (ld_lsb_q)
            2'd0:    byte_v = i_dmem_rdata[7:0];
            2'd1:    byte_v = i_dmem_rdata[15:8];
            2'd2:    byte_v = i_dmem_rdata[23:16];
            default: byte_v = i_dmem_rdata[31:24];
        endcase
        half_v = ld_lsb_q[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
        case (ld_funct3_q)
            3'b000:  load_fmt = {{24{byte_v[7]}}, byte_v};
            3'b001:  load_fmt = {{16{half_v[15]}}, half_v};
            3'b100:  load_fmt = {24'd0, byte_v};
            3'b101:  load_fmt = {16'd0, half_v};
            default: load_fmt = i_dmem_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ld_rd_d     = ld_rd_q;
        ld_rd_en_d  = ld_rd_en_q;
        ld_funct3_d = ld_funct3_q;
        ld_lsb_d    = ld_lsb_q;
        w_en_d      = 1'b0;
        rd_d        = rd_q;
        wdata_d     = wdata_q;
        err_d       = 1'b0;
        case (state_q)
            IDLE: begin
                // Stall is low in IDLE, so i_valid alone means accept.
                // A stray ack arriving here is dropped.
                if (i_valid) begin
                    if (!i_is_load) begin
                        w_en_d  = i_rd_en && (i_rd != 5'd0);
                        rd_d    = i_rd;
                        wdata_d = i_alu_result;
                    end else if (load_bad) begin
                        err_d = 1'b1;
                    end else begin
                        ld_rd_d     = i_rd;
                        ld_rd_en_d  = i_rd_en;
                        ld_funct3_d = i_funct3;
                        ld_lsb_d    = i_addr_lsb;
                        cnt_d       = 8'd0;
                        state_d     = WAIT;
                    end
                end
            end
            WAIT: begin
                // Ack is checked first, so an ack on the expiry cycle
                // completes the load.
                if (i_dmem_ack) begin
                    w_en_d  = ld_rd_en_q && (ld_rd_q != 5'd0);
                    rd_d    = ld_rd_q;
                    wdata_d = load_fmt;
                    state_d = IDLE;
                end else if (cnt_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            ld_rd_q     <= 5'd0;
            ld_rd_en_q  <= 1'b0;
            ld_funct3_q <= 3'd0;
            ld_lsb_q    <= 2'd0;
            w_en_q      <= 1'b0;
            rd_q        <= 5'd0;
            wdata_q     <= 32'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ld_rd_q     <= ld_rd_d;
            ld_rd_en_q  <= ld_rd_en_d;
            ld_funct3_q <= ld_funct3_d;
            ld_lsb_q    <= ld_lsb_d;
            w_en_q      <= w_en_d;
            rd_q        <= rd_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
        end
    end

    assign o_stall    = (state_q == WAIT);
    assign o_w_en     = w_en_q;
    assign o_rd       = rd_q;
    assign o_rd_wdata = wdata_q;
    assign o_load_err = err_q;

`ifdef WB_FORWARD_EN
    // One-entry history of last cycle's write. It lets decode bypass a
    // value for one more cycle, covering reads issued while the file is
    // being written.
    logic        hist_vld_q, hist_vld_d;
    logic [4:0]  hist_rd_q, hist_rd_d;
    logic [31:0] hist_data_q, hist_data_d;

    always_comb begin
        hist_vld_d  = w_en_q;
        hist_rd_d   = rd_q;
        hist_data_d = wdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_vld_q  <= 1'b0;
            hist_rd_q   <= 5'd0;
            hist_data_q <= 32'd0;
        end else begin
            hist_vld_q  <= hist_vld_d;
            hist_rd_q   <= hist_rd_d;
            hist_data_q <= hist_data_d;
        end
    end

    assign o_fwd_valid = w_en_q | hist_vld_q;
    assign o_fwd_rd    = w_en_q ? rd_q    : (hist_vld_q ? hist_rd_q   : 5'd0);
    assign o_fwd_data  = w_en_q ? wdata_q : (hist_vld_q ? hist_data_q : 32'd0);
`else
    assign o_fwd_valid = 1'b0;
    assign o_fwd_rd    = 5'd0;
    assign o_fwd_data  = 32'd0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic [4:0]  i_rd;
    logic        i_rd_en;
    logic [31:0] i_alu_result;
    logic        i_is_load;
    logic [2:0]  i_funct3;
    logic [1:0]  i_addr_lsb;
    logic        o_stall;
    logic        i_dmem_ack;
    logic [31:0] i_dmem_rdata;
    logic        o_w_en;
    logic [4:0]  o_rd;
    logic [31:0] o_rd_wdata;
    logic        o_load_err;
    logic        o_fwd_valid;
    logic [4:0]  o_fwd_rd;
    logic [31:0] o_fwd_data;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    wb_stage #(.ACK_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .i_valid(i_valid), .i_rd(i_rd), .i_rd_en(i_rd_en),
        .i_alu_result(i_alu_result), .i_is_load(i_is_load),
        .i_funct3(i_funct3), .i_addr_lsb(i_addr_lsb), .o_stall(o_stall),
        .i_dmem_ack(i_dmem_ack), .i_dmem_rdata(i_dmem_rdata),
        .o_w_en(o_w_en), .o_rd(o_rd), .o_rd_wdata(o_rd_wdata),
        .o_load_err(o_load_err), .o_fwd_valid(o_fwd_valid),
        .o_fwd_rd(o_fwd_rd), .o_fwd_data(o_fwd_data)
    );

    typedef struct {
        string       name;
        bit          is_load;
        logic [2:0]  f3;
        logic [1:0]  lsb;
        logic [4:0]  rd;
        bit          rd_en;
        logic [31:0] alu;
        logic [31:0] rdata;
        int          dly;       // ack arrives in the dly-th cycle after accept
        bit          exp_wen;
        bit          exp_err;
        logic [31:0] exp_data;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural reference: the load rules, computed directly.
    function automatic bit legal(input logic [2:0] f3, input logic [1:0] lsb);
        int size;
        if (f3 == 3'd0 || f3 == 3'd4)      size = 1;
        else if (f3 == 3'd1 || f3 == 3'd5) size = 2;
        else if (f3 == 3'd2)               size = 4;
        else                               return 0;
        return (int'(lsb) % size) == 0;
    endfunction

    function automatic logic [31:0] fmt(input logic [2:0] f3, input logic [1:0] lsb,
                                        input logic [31:0] w);
        logic [31:0] sh;
        logic [7:0]  b;
        logic [15:0] h;
        sh = w >> (8 * int'(lsb));
        b  = sh[7:0];
        h  = sh[15:0];
        case (f3)
            3'd0:    return 32'(int'($signed(b)));
            3'd1:    return 32'(int'($signed(h)));
            3'd4:    return 32'(b);
            3'd5:    return 32'(h);
            default: return w;
        endcase
    endfunction

    function automatic vec_t mk(input string nm, input bit ld, input logic [2:0] f3,
                                input logic [1:0] lsb, input logic [4:0] rd, input bit rd_en,
                                input logic [31:0] alu, input logic [31:0] rdata, input int dly,
                                input bit wen, input bit err, input logic [31:0] data);
        vec_t v;
        v.name = nm; v.is_load = ld; v.f3 = f3; v.lsb = lsb; v.rd = rd; v.rd_en = rd_en;
        v.alu = alu; v.rdata = rdata; v.dly = dly;
        v.exp_wen = wen; v.exp_err = err; v.exp_data = data;
        return v;
    endfunction

    // Presents one instruction, services its load and checks the result.
    // All waits are bounded by TMO cycles.
    task automatic run(input vec_t v);
        bit good;
        good = v.is_load && legal(v.f3, v.lsb);
        @(negedge clk);
        chk({v.name, "/idle_stall"}, 32'(o_stall), 32'd0);
        chk({v.name, "/idle_wen"}, 32'(o_w_en), 32'd0);
        chk({v.name, "/idle_err"}, 32'(o_load_err), 32'd0);
        i_valid = 1'b1; i_is_load = v.is_load; i_funct3 = v.f3; i_addr_lsb = v.lsb;
        i_rd = v.rd; i_rd_en = v.rd_en; i_alu_result = v.alu;
        i_dmem_rdata = $urandom;
        @(negedge clk);
        i_valid = 1'b0;
        i_alu_result = $urandom;
        if (good) begin
            for (int c = 1; c <= TMO; c++) begin
                chk({v.name, "/wait_stall"}, 32'(o_stall), 32'd1);
                chk({v.name, "/wait_wen"}, 32'(o_w_en), 32'd0);
                if (c == v.dly) begin
                    i_dmem_ack = 1'b1;
                    i_dmem_rdata = v.rdata;
                end
                @(negedge clk);
                i_dmem_ack = 1'b0;
                i_dmem_rdata = $urandom;
                if (c == v.dly) break;
            end
        end
        chk({v.name, "/stall"}, 32'(o_stall), 32'd0);
        chk({v.name, "/wen"}, 32'(o_w_en), 32'(v.exp_wen));
        chk({v.name, "/err"}, 32'(o_load_err), 32'(v.exp_err));
        if (v.exp_wen) begin
            chk({v.name, "/rd"}, 32'(o_rd), 32'(v.rd));
            chk({v.name, "/data"}, o_rd_wdata, v.exp_data);
        end
    endtask

    vec_t tbl[$];
    vec_t rv;

    initial begin
        rst = 1'b1; i_valid = 1'b0; i_rd = '0; i_rd_en = 1'b0; i_alu_result = '0;
        i_is_load = 1'b0; i_funct3 = '0; i_addr_lsb = '0; i_dmem_ack = 1'b0; i_dmem_rdata = '0;

        tbl.push_back(mk("add_x5",  0, 3'd0, 2'd0, 5'd5, 1, 32'h1234_5678, 0, 0, 1, 0, 32'h1234_5678));
        tbl.push_back(mk("add_x0",  0, 3'd0, 2'd0, 5'd0, 1, 32'hDEAD_BEEF, 0, 0, 0, 0, 0));
        tbl.push_back(mk("add_noen",0, 3'd0, 2'd0, 5'd3, 0, 32'h0000_0011, 0, 0, 0, 0, 0));
        tbl.push_back(mk("lb3",     1, 3'd0, 2'd3, 5'd9, 1, 0, 32'h80FF_0000, 3, 1, 0, 32'hFFFF_FF80));
        tbl.push_back(mk("lbu3",    1, 3'd4, 2'd3, 5'd9, 1, 0, 32'h80FF_0000, 3, 1, 0, 32'h0000_0080));
        tbl.push_back(mk("lh2",     1, 3'd1, 2'd2, 5'd10,1, 0, 32'h8001_7FFF, 1, 1, 0, 32'hFFFF_8001));
        tbl.push_back(mk("lhu2",    1, 3'd5, 2'd2, 5'd10,1, 0, 32'h8001_7FFF, 2, 1, 0, 32'h0000_8001));
        tbl.push_back(mk("lw0",     1, 3'd2, 2'd0, 5'd11,1, 0, 32'h8001_7FFF, 1, 1, 0, 32'h8001_7FFF));
        tbl.push_back(mk("lh0_pos", 1, 3'd1, 2'd0, 5'd12,1, 0, 32'h8001_7FFF, 2, 1, 0, 32'h0000_7FFF));
        tbl.push_back(mk("lb1",     1, 3'd0, 2'd1, 5'd13,1, 0, 32'h0000_7F00, 1, 1, 0, 32'h0000_007F));
        tbl.push_back(mk("lw_mis",  1, 3'd2, 2'd2, 5'd4, 1, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk("f3_011",  1, 3'd3, 2'd0, 5'd4, 1, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk("lh_mis",  1, 3'd5, 2'd1, 5'd4, 1, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk("timeout", 1, 3'd0, 2'd0, 5'd6, 1, 0, 32'h55, 99, 0, 1, 0));
        tbl.push_back(mk("ack_exp", 1, 3'd2, 2'd0, 5'd7, 1, 0, 32'hCAFE_F00D, TMO, 1, 0, 32'hCAFE_F00D));
        tbl.push_back(mk("lw_x0",   1, 3'd2, 2'd0, 5'd0, 1, 0, 32'h1111_2222, 1, 0, 0, 0));

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst/wen", 32'(o_w_en), 0);
        chk("rst/rd", 32'(o_rd), 0);
        chk("rst/data", o_rd_wdata, 0);
        chk("rst/err", 32'(o_load_err), 0);
        chk("rst/stall", 32'(o_stall), 0);
        chk("rst/fwd_v", 32'(o_fwd_valid), 0);
        chk("rst/fwd_d", o_fwd_data, 0);

        foreach (tbl[i]) run(tbl[i]);

        // An ack that arrives after a timeout lands in IDLE and is ignored.
        run(mk("timeout2", 1, 3'd2, 2'd0, 5'd8, 1, 0, 0, 99, 0, 1, 0));
        i_dmem_ack = 1'b1; i_dmem_rdata = 32'h9999_9999;
        @(negedge clk);
        i_dmem_ack = 1'b0;
        chk("late_ack/wen", 32'(o_w_en), 0);
        chk("late_ack/err", 32'(o_load_err), 0);
        chk("late_ack/stall", 32'(o_stall), 0);

        // Back-to-back non-loads, one per cycle.
        @(negedge clk);
        i_valid = 1'b1; i_is_load = 1'b0; i_rd_en = 1'b1; i_rd = 5'd1; i_alu_result = 32'hA;
        @(negedge clk);
        i_rd = 5'd2; i_alu_result = 32'hB;
        chk("b2b1/wen", 32'(o_w_en), 1);
        chk("b2b1/rd", 32'(o_rd), 1);
        chk("b2b1/data", o_rd_wdata, 32'hA);
        @(negedge clk);
        i_valid = 1'b0;
        chk("b2b2/wen", 32'(o_w_en), 1);
        chk("b2b2/rd", 32'(o_rd), 2);
        chk("b2b2/data", o_rd_wdata, 32'hB);

        // Reset during WAIT: back to IDLE, no write, no error, and a
        // following ack is ignored.
        @(negedge clk);
        i_valid = 1'b1; i_is_load = 1'b1; i_funct3 = 3'd2; i_addr_lsb = 2'd0; i_rd = 5'd3;
        @(negedge clk);
        i_valid = 1'b0;
        chk("rstw/stall_pre", 32'(o_stall), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstw/stall", 32'(o_stall), 0);
        chk("rstw/wen", 32'(o_w_en), 0);
        chk("rstw/err", 32'(o_load_err), 0);
        i_dmem_ack = 1'b1; i_dmem_rdata = 32'h7777_7777;
        @(negedge clk);
        i_dmem_ack = 1'b0;
        chk("rstw/ack_wen", 32'(o_w_en), 0);
        chk("rstw/ack_err", 32'(o_load_err), 0);

        // Forwarding port: ADD x7 = 0xA5.
        @(negedge clk);
        i_valid = 1'b1; i_is_load = 1'b0; i_rd = 5'd7; i_rd_en = 1'b1; i_alu_result = 32'hA5;
        @(negedge clk);
        i_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
`ifdef WB_FORWARD_EN
            chk("fwd/valid", 32'(o_fwd_valid), (c < 2) ? 32'd1 : 32'd0);
            if (c < 2) begin
                chk("fwd/rd", 32'(o_fwd_rd), 32'd7);
                chk("fwd/data", o_fwd_data, 32'hA5);
            end
`else
            chk("nofwd/valid", 32'(o_fwd_valid), 0);
            chk("nofwd/rd", 32'(o_fwd_rd), 0);
            chk("nofwd/data", o_fwd_data, 0);
`endif
            @(negedge clk);
        end

        // Random instructions checked against the reference rules.
        for (int n = 0; n < 80; n++) begin
            rv.name    = "rand";
            rv.is_load = ($urandom_range(1, 0) == 1);
            rv.f3      = 3'($urandom_range(7, 0));
            rv.lsb     = 2'($urandom_range(3, 0));
            rv.rd      = ($urandom_range(7, 0) == 0) ? 5'd0 : 5'($urandom_range(31, 1));
            rv.rd_en   = ($urandom_range(3, 0) != 0);
            rv.alu     = $urandom;
            rv.rdata   = $urandom;
            rv.dly     = $urandom_range(TMO + 2, 1);
            if (!rv.is_load) begin
                rv.exp_wen  = rv.rd_en && rv.rd != 0;
                rv.exp_err  = 0;
                rv.exp_data = rv.alu;
            end else if (!legal(rv.f3, rv.lsb) || rv.dly > TMO) begin
                rv.exp_wen  = 0;
                rv.exp_err  = 1;
                rv.exp_data = 0;
            end else begin
                rv.exp_wen  = rv.rd_en && rv.rd != 0;
                rv.exp_err  = 0;
                rv.exp_data = fmt(rv.f3, rv.lsb, rv.rdata);
            end
            run(rv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the rv32i pipeline, directly upstream of the 32-entry integer register file. Accepts retiring instructions from the memory stage, waits for and formats load data (byte/halfword extract, sign/zero extend), and drives the registered write port (`o_w_en`, `o_rd`, `o_rd_wdata`) that the register file samples on the next rising edge. Back-pressures the memory stage while a load is outstanding and flags misaligned, illegal or timed-out loads.

## Interface
- `ACK_TIMEOUT`, 16, max cycles waited in WAIT for `i_dmem_ack` before abandoning the load (range 1..255)
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `i_valid`  in  1  memory stage presents a retiring instruction
- `i_rd`  in  5  destination register
- `i_rd_en`  in  1  instruction writes `rd`
- `i_alu_result`  in  32  non-load result
- `i_is_load`  in  1  instruction is a load
- `i_funct3`  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- `i_addr_lsb`  in  2  load address bits [1:0]
- `o_stall`  out  1  upstream must hold; `i_valid` ignored while high
- `i_dmem_ack`  in  1  load data valid this cycle
- `i_dmem_rdata`  in  32  word-aligned load data, little-endian
- `o_w_en`  out  1  register-file write enable, registered
- `o_rd`  out  5  register-file write address, registered
- `o_rd_wdata`  out  32  register-file write data, registered
- `o_load_err`  out  1  one-cycle pulse: misaligned, illegal funct3, or timeout
- `o_fwd_valid`, `o_fwd_rd` (5), `o_fwd_data` (32)  out  forwarding port (see Configuration)

## Operation
- FSM: IDLE, WAIT. Reset -> IDLE.
- Accept = `i_valid && !o_stall`. `o_stall` = (state == WAIT), combinational from state only.
- IDLE, accept, `!i_is_load`: next edge `o_w_en` = `i_rd_en && i_rd != 0`, `o_rd` = `i_rd`, `o_rd_wdata` = `i_alu_result`.
- IDLE, accept, load, legal and aligned: latch rd, rd_en, funct3, lsb; clear timeout counter; -> WAIT. `o_w_en` = 0 next cycle.
- Misaligned: LH/LHU with lsb[0]=1; LW with lsb != 0. Illegal: funct3 in {011,110,111}. Either: stay IDLE, no write, `o_load_err` = 1 next cycle.
- WAIT, `i_dmem_ack`: format data, next edge `o_w_en` = latched rd_en && rd != 0, -> IDLE.
- Formatting: LB/LBU byte = rdata[8*lsb +: 8]; LH/LHU half = rdata[16*lsb[1] +: 16]; LB/LH sign-extend to 32, LBU/LHU zero-extend; LW passes word.
- WAIT, no ack: counter increments; when counter reaches `ACK_TIMEOUT-1` without ack -> IDLE, `o_load_err` pulse, no write. Late ack arriving in IDLE is ignored.
- `i_dmem_ack` in IDLE always ignored. `i_valid` in WAIT ignored (upstream holds it).
- Writes to x0 never assert `o_w_en`.

## Timing
- Reset values: `o_w_en`=0, `o_rd`=0, `o_rd_wdata`=0, `o_load_err`=0, `o_stall`=0, fwd outputs 0; state IDLE; counter 0.
- Non-load latency: accept at edge N -> write port valid cycle N+1, register file updated at edge N+2.
- Load latency: ack in cycle K -> write port valid cycle K+1. Minimum 2 cycles from accept (ack cannot be same cycle as accept).
- `o_w_en` and `o_load_err` are single-cycle pulses per instruction; never both high.
- Back-to-back non-loads sustain one per cycle.
- Ack and timeout expiry in same cycle: ack wins, write performed, no error.
- `rst` mid-WAIT: -> IDLE next edge, no write, no error pulse, `o_stall` drops.

## Configuration
- Macro `WB_FORWARD_EN`.
- Defined: `o_fwd_valid`/`o_fwd_rd`/`o_fwd_data` mirror `o_w_en`/`o_rd`/`o_rd_wdata` of the current cycle, plus a one-entry history register holding the previous cycle's write; `o_fwd_*` present the current write if `o_w_en`, else the history entry (valid for one cycle after the write). Lets decode bypass reads issued the same cycle the file is written.
- Not defined: `o_fwd_*` tied to 0, history register absent.

## Test plan
- Reset, then ADD result 0x1234_5678 to x5 -> one cycle later `o_w_en`=1, `o_rd`=5, `o_rd_wdata`=0x12345678; write to x0 -> `o_w_en`=0.
- LB lsb=3, rdata=0x80FF_0000, ack 3 cycles later -> `o_stall` high 3 cycles, then write 0xFFFF_FF80; LBU same -> 0x0000_0080.
- LH lsb=2, rdata=0x8001_7FFF -> 0xFFFF_8001; LHU -> 0x0000_8001; LW lsb=0 -> 0x8001_7FFF.
- LW lsb=2 and funct3=011 -> no stall, `o_w_en`=0, `o_load_err` one-cycle pulse each.
- ACK_TIMEOUT=4, load with no ack -> `o_stall` high 4 cycles, `o_load_err` pulse, no write; later ack ignored; ack on expiry cycle -> write, no error.
- `rst` asserted during WAIT -> IDLE, no write; with `WB_FORWARD_EN`, ADD to x7 = 0xA5 -> fwd valid with x7/0xA5 for 2 consecutive cycles.
